// File: rtl/ramb_ctrl_pkg.sv
// rtl/ramb_ctrl_pkg.sv - shared types and constants for the block-RAM arbiter
package ramb_ctrl_pkg;

  localparam int RAM_DEPTH = 2048;
  localparam int RAM_AW    = 11;
  localparam int RAM_DW    = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ctrl_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/ramb_rr_arb2.sv
// rtl/ramb_rr_arb2.sv - two-way round-robin grant with last-winner pointer
module ramb_rr_arb2
  import ramb_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_t last_q;

  // bit 0 is requester A, bit 1 is requester B
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last_q == REQ_B)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_q <= REQ_B;
    end else if (gnt[0]) begin
      last_q <= REQ_A;
    end else if (gnt[1]) begin
      last_q <= REQ_B;
    end
  end

endmodule

// File: rtl/ramb16_s9_arbiter.sv
// rtl/ramb16_s9_arbiter.sv - two-master arbiter and clear sequencer for a 2048x9 block RAM
module ramb16_s9_arbiter
  import ramb_ctrl_pkg::*;
#(
  parameter logic [8:0] CLR_VAL = 9'h000,
  parameter int         DEPTH   = RAM_DEPTH
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              A_REQ,
  input  logic              A_WE,
  input  logic [RAM_AW-1:0] A_ADDR,
  input  logic [RAM_DW-1:0] A_DI,
  input  logic              A_DIP,
  output logic              A_ACK,
  output logic              A_RVALID,
  input  logic              B_REQ,
  input  logic              B_WE,
  input  logic [RAM_AW-1:0] B_ADDR,
  input  logic [RAM_DW-1:0] B_DI,
  input  logic              B_DIP,
  output logic              B_ACK,
  output logic              B_RVALID,
  output logic [RAM_DW-1:0] RDATA,
  output logic              RDATAP,
  input  logic              CLR,
  output logic              CLR_BUSY,
  output logic              CLR_DONE,
  output logic              RAM_EN,
  output logic              RAM_WE,
  output logic              RAM_SSR,
  output logic [RAM_AW-1:0] RAM_ADDR,
  output logic [RAM_DW-1:0] RAM_DI,
  output logic              RAM_DIP,
  input  logic [RAM_DW-1:0] RAM_DO,
  input  logic              RAM_DOP
);

  ctrl_state_t       state_q, state_d;
  logic [RAM_AW-1:0] clr_cnt_q;
  logic              a_rvalid_q, b_rvalid_q, clr_done_q;
  logic              arb_en, clr_last;
  logic [1:0]        gnt;

  // RST_N gates the grant so ACK and RAM strobes drop immediately on reset
  assign arb_en   = RST_N && (state_q == IDLE) && !CLR;
  assign clr_last = (state_q == CLEAR) && (clr_cnt_q == RAM_AW'(DEPTH - 1));

  ramb_rr_arb2 u_arb (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (arb_en),
    .req   ({B_REQ, A_REQ}),
    .gnt   (gnt)
  );

  always_comb begin
    state_d  = state_q;
    RAM_EN   = 1'b0;
    RAM_WE   = 1'b0;
    RAM_ADDR = '0;
    RAM_DI   = '0;
    RAM_DIP  = 1'b0;
    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEAR;
        end
        if (gnt[0]) begin
          RAM_EN   = 1'b1;
          RAM_WE   = A_WE;
          RAM_ADDR = A_ADDR;
          RAM_DI   = A_DI;
          RAM_DIP  = A_DIP;
        end else if (gnt[1]) begin
          RAM_EN   = 1'b1;
          RAM_WE   = B_WE;
          RAM_ADDR = B_ADDR;
          RAM_DI   = B_DI;
          RAM_DIP  = B_DIP;
        end
      end
      CLEAR: begin
        RAM_EN   = 1'b1;
        RAM_WE   = 1'b1;
        RAM_ADDR = clr_cnt_q;
        RAM_DI   = CLR_VAL[7:0];
        RAM_DIP  = CLR_VAL[8];
        if (clr_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // the sweep counter wraps 2047 -> 0 on its own, ready for the next clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_rvalid_q <= gnt[0] & ~A_WE;
      b_rvalid_q <= gnt[1] & ~B_WE;
      clr_done_q <= clr_last;
      if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
    end
  end

  assign A_ACK    = gnt[0];
  assign B_ACK    = gnt[1];
  assign A_RVALID = a_rvalid_q;
  assign B_RVALID = b_rvalid_q;
  assign RDATA    = RAM_DO;
  assign RDATAP   = RAM_DOP;
  assign CLR_BUSY = (state_q == CLEAR);
  assign CLR_DONE = clr_done_q;
  assign RAM_SSR  = 1'b0;

endmodule

// File: tb/tb_ramb16_s9_arbiter.sv
// tb/tb_ramb16_s9_arbiter.sv - self-checking bench for ramb16_s9_arbiter
module tb_ramb16_s9_arbiter;

  localparam logic [8:0] CV = 9'h1FF;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        A_REQ = 1'b0, B_REQ = 1'b0, A_WE = 1'b0, B_WE = 1'b0;
  logic [10:0] A_ADDR = '0, B_ADDR = '0;
  logic [7:0]  A_DI = '0, B_DI = '0;
  logic        A_DIP = 1'b0, B_DIP = 1'b0;
  logic        CLR = 1'b0;
  logic        A_ACK, B_ACK, A_RVALID, B_RVALID, RDATAP, CLR_BUSY, CLR_DONE;
  logic        RAM_EN, RAM_WE, RAM_SSR, RAM_DIP, RAM_DOP;
  logic [7:0]  RDATA, RAM_DI, RAM_DO;
  logic [10:0] RAM_ADDR;

  always #5 CLK = ~CLK;

  ramb16_s9_arbiter #(.CLR_VAL(CV), .DEPTH(2048)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_DI(A_DI), .A_DIP(A_DIP),
    .A_ACK(A_ACK), .A_RVALID(A_RVALID),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_DI(B_DI), .B_DIP(B_DIP),
    .B_ACK(B_ACK), .B_RVALID(B_RVALID),
    .RDATA(RDATA), .RDATAP(RDATAP),
    .CLR(CLR), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_SSR(RAM_SSR), .RAM_ADDR(RAM_ADDR),
    .RAM_DI(RAM_DI), .RAM_DIP(RAM_DIP), .RAM_DO(RAM_DO), .RAM_DOP(RAM_DOP)
  );

  // RAM primitive: seeded on the first edge, 1-cycle read latency
  bit [8:0]    ram [0:2047];
  bit [8:0]    ram_q;
  bit          seeded;
  int unsigned salt;

  function automatic logic [8:0] seed_word(input int a, input int unsigned s);
    return 9'((a * 37 + int'(s)) ^ (a >> 2));
  endfunction

  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < 2048; i++) ram[i] <= seed_word(i, salt);
      seeded <= 1'b1;
    end else if (RAM_EN) begin
      if (RAM_WE) ram[RAM_ADDR] <= {RAM_DIP, RAM_DI};
      else        ram_q <= ram[RAM_ADDR];
    end
  end
  assign RAM_DO  = ram_q[7:0];
  assign RAM_DOP = ram_q[8];

  int          checks = 0, errors = 0;
  logic [8:0]  ref_mem [0:2047];
  int          clr_left, done_cnt, busy_n, ack_n;
  bit          last_b, exp_rva, exp_rvb, exp_done, m_ga, m_gb, a_act, b_act;
  logic [8:0]  exp_rd, obs_rd;
  bit          obs_a, obs_b, obs_rva, obs_rvb, obs_done, obs_busy;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    clr_left = 0;
    last_b   = 1'b1;
    exp_rva  = 1'b0;
    exp_rvb  = 1'b0;
    exp_done = 1'b0;
  endtask

  task automatic set_a(input bit r, input bit we, input logic [10:0] ad, input logic [8:0] d);
    A_REQ = r; A_WE = we; A_ADDR = ad; A_DI = d[7:0]; A_DIP = d[8];
  endtask

  task automatic set_b(input bit r, input bit we, input logic [10:0] ad, input logic [8:0] d);
    B_REQ = r; B_WE = we; B_ADDR = ad; B_DI = d[7:0]; B_DIP = d[8];
  endtask

  // called at a falling edge with inputs applied; returns at the next falling edge
  task automatic tick();
    bit ea, eb;
    logic [10:0] eaddr;
    #1;
    obs_a = A_ACK; obs_b = B_ACK; obs_rva = A_RVALID; obs_rvb = B_RVALID;
    obs_done = CLR_DONE; obs_busy = CLR_BUSY; obs_rd = {RDATAP, RDATA};
    if (CLR_DONE) done_cnt++;
    ea = 1'b0; eb = 1'b0; eaddr = '0;
    if (clr_left == 0 && !CLR) begin
      ea = A_REQ && (!B_REQ || last_b);
      eb = B_REQ && !ea;
    end
    check_eq("a_ack", A_ACK, ea);
    check_eq("b_ack", B_ACK, eb);
    check_eq("ram_en", RAM_EN, (clr_left > 0) || ea || eb);
    check_eq("ram_we", RAM_WE, (clr_left > 0) || (ea && A_WE) || (eb && B_WE));
    check_eq("clr_busy", CLR_BUSY, clr_left > 0);
    check_eq("clr_done", CLR_DONE, exp_done);
    check_eq("a_rvalid", A_RVALID, exp_rva);
    check_eq("b_rvalid", B_RVALID, exp_rvb);
    check_eq("ram_ssr", RAM_SSR, 0);
    if (exp_rva || exp_rvb) check_eq("rdata", {RDATAP, RDATA}, exp_rd);
    if (clr_left > 0) begin
      eaddr = 11'(2048 - clr_left);
      check_eq("clr_addr", RAM_ADDR, eaddr);
      check_eq("clr_data", {RAM_DIP, RAM_DI}, CV);
    end else if (ea || eb) begin
      check_eq("grant_addr", RAM_ADDR, ea ? A_ADDR : B_ADDR);
      if ((ea && A_WE) || (eb && B_WE))
        check_eq("grant_data", {RAM_DIP, RAM_DI}, ea ? {A_DIP, A_DI} : {B_DIP, B_DI});
    end
    exp_rva = ea && !A_WE;
    exp_rvb = eb && !B_WE;
    exp_done = 1'b0;
    if (ea) begin
      last_b = 1'b0;
      if (A_WE) ref_mem[A_ADDR] = {A_DIP, A_DI};
      else      exp_rd = ref_mem[A_ADDR];
    end
    if (eb) begin
      last_b = 1'b1;
      if (B_WE) ref_mem[B_ADDR] = {B_DIP, B_DI};
      else      exp_rd = ref_mem[B_ADDR];
    end
    m_ga = ea;
    m_gb = eb;
    if (clr_left > 0) begin
      ref_mem[eaddr] = CV;
      clr_left--;
      exp_done = (clr_left == 0);
    end else if (CLR) begin
      clr_left = 2048;
    end
    @(negedge CLK);
  endtask

  initial begin
    salt = $urandom;
    for (int i = 0; i < 2048; i++) ref_mem[i] = seed_word(i, salt);
    model_reset();
    done_cnt = 0;

    // reset with both requests pending: nothing may be granted
    set_a(1, 0, 11'h005, 9'h0);
    set_b(1, 0, 11'h006, 9'h0);
    repeat (2) @(negedge CLK);
    #1;
    check_eq("rst_a_ack", A_ACK, 0);
    check_eq("rst_b_ack", B_ACK, 0);
    check_eq("rst_ram_en", RAM_EN, 0);
    check_eq("rst_ram_we", RAM_WE, 0);
    check_eq("rst_rvalid", {A_RVALID, B_RVALID}, 0);
    check_eq("rst_busy", CLR_BUSY, 0);
    check_eq("rst_done", CLR_DONE, 0);
    @(negedge CLK);
    set_b(0, 0, 11'h0, 9'h0);
    RST_N = 1'b1;

    // A reads 0x005 alone
    tick();
    check_eq("a5_ack", obs_a, 1);
    set_a(0, 0, 11'h0, 9'h0);
    tick();
    check_eq("a5_rvalid", obs_rva, 1);
    check_eq("a5_rdata", obs_rd, seed_word(5, salt));

    // B alone so the pointer says "last = B", then four contended cycles
    set_b(1, 0, 11'h200, 9'h0);
    tick();
    set_a(1, 0, 11'h010, 9'h0);
    set_b(1, 1, 11'h123, 9'h1A5);
    tick();
    check_eq("rr1", {obs_a, obs_b}, 2'b10);
    set_a(1, 0, 11'h123, 9'h0);
    tick();
    check_eq("rr2", {obs_a, obs_b}, 2'b01);
    set_b(1, 1, 11'h124, 9'h03C);
    tick();
    check_eq("rr3", {obs_a, obs_b}, 2'b10);
    set_a(1, 0, 11'h005, 9'h0);
    tick();
    check_eq("rr4", {obs_a, obs_b}, 2'b01);
    check_eq("rd_123", obs_rd, 9'h1A5);
    set_b(0, 0, 11'h0, 9'h0);
    tick();

    // read granted, then CLR the following cycle while B is requesting
    set_a(1, 0, 11'h020, 9'h0);
    tick();
    set_a(0, 0, 11'h0, 9'h0);
    set_b(1, 0, 11'h7FF, 9'h0);
    CLR = 1'b1;
    tick();
    check_eq("clr_rvalid", obs_rva, 1);
    check_eq("clr_cycle_ack", obs_b, 0);
    busy_n = 0;
    ack_n = 0;
    for (int i = 0; i < 2048; i++) begin
      CLR = (i == 500);
      tick();
      busy_n += obs_busy;
      ack_n += (obs_a || obs_b) ? 1 : 0;
    end
    CLR = 1'b0;
    check_eq("busy_cycles", busy_n, 2048);
    check_eq("clear_acks", ack_n, 0);
    tick();
    check_eq("done_pulse", obs_done, 1);
    check_eq("done_b_ack", obs_b, 1);
    set_b(0, 0, 11'h0, 9'h0);
    set_a(1, 0, 11'h000, 9'h0);
    tick();
    check_eq("rd_7ff", obs_rd, 9'h1FF);
    set_a(0, 0, 11'h0, 9'h0);
    tick();
    check_eq("rd_000", obs_rd, 9'h1FF);
    check_eq("done_count", done_cnt, 1);

    // reset at clear count 100
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    repeat (100) tick();
    #1;
    check_eq("cnt100", RAM_ADDR, 11'd100);
    set_a(1, 0, 11'h001, 9'h0);
    set_b(1, 0, 11'h002, 9'h0);
    RST_N = 1'b0;
    #1;
    check_eq("mid_a_ack", A_ACK, 0);
    check_eq("mid_b_ack", B_ACK, 0);
    check_eq("mid_ram_en", RAM_EN, 0);
    check_eq("mid_ram_we", RAM_WE, 0);
    check_eq("mid_busy", CLR_BUSY, 0);
    check_eq("mid_done", CLR_DONE, 0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check_eq("post_rst_a_first", obs_a, 1);
    set_a(0, 0, 11'h0, 9'h0);
    repeat (3) tick();
    check_eq("no_done_after_abort", done_cnt, 1);

    // randomized traffic over a small address window
    set_b(0, 0, 11'h0, 9'h0);
    a_act = 1'b0;
    b_act = 1'b0;
    repeat (400) begin
      if (!a_act && $urandom_range(0, 2) != 0) begin
        a_act = 1'b1;
        set_a(1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)), 9'($urandom));
      end
      if (!b_act && $urandom_range(0, 2) != 0) begin
        b_act = 1'b1;
        set_b(1, 1'($urandom_range(0, 1)), 11'($urandom_range(0, 31)), 9'($urandom));
      end
      tick();
      if (m_ga) begin a_act = 1'b0; A_REQ = 1'b0; end
      if (m_gb) begin b_act = 1'b0; B_REQ = 1'b0; end
    end
    A_REQ = 1'b0;
    B_REQ = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ramb16_s9_arbiter.md
# ramb16_s9_arbiter

Two-requester arbiter and clear sequencer for one single-port 2048x8+1 block RAM, 1-cycle read latency, 9-bit wide. Two independent masters (A, B) share the RAM through a round-robin, one-transfer-per-cycle handshake. A built-in clear engine sweeps every location to a constant value on command. The block sits directly in front of the RAM primitive; it is the only driver of the RAM's control pins.

## Interface
Parameters:
- CLR_VAL, 9'h000, word written by the clear engine; bit 8 goes to the parity bit.
- DEPTH, 2048, number of RAM locations; fixed, address width 11.

Ports:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- A_REQ, B_REQ  in  1  transfer request, held until acknowledged.
- A_WE, B_WE  in  1  1 = write, 0 = read; qualified by REQ.
- A_ADDR, B_ADDR  in  11  word address.
- A_DI, B_DI  in  8  write data.
- A_DIP, B_DIP  in  1  write parity bit.
- A_ACK, B_ACK  out  1  transfer accepted this cycle.
- A_RVALID, B_RVALID  out  1  read data valid on RDATA/RDATAP this cycle.
- RDATA  out  8  read data, shared by both requesters; the RVALID strobes qualify it.
- RDATAP  out  1  read parity bit, shared.
- CLR  in  1  start clear, pulse.
- CLR_BUSY  out  1  clear in progress.
- CLR_DONE  out  1  one-cycle pulse after the last clear write.
- RAM_EN, RAM_WE  out  1  RAM enable and write enable.
- RAM_SSR  out  1  tied 0.
- RAM_ADDR  out  11  RAM address.
- RAM_DI  out  8  RAM write data.
- RAM_DIP  out  1  RAM write parity.
- RAM_DO  in  8  RAM read data.
- RAM_DOP  in  1  RAM read parity.

## Operation
- FSM states:
  - IDLE serves requesters.
  - CLEAR runs the sweep.
  - Transitions: IDLE -> CLEAR when CLR=1; CLEAR -> IDLE after address 2047 is written.
- Arbitration in IDLE:
  - Only one REQ high: that requester wins.
  - Both REQ high: the requester not granted last wins.
  - Round-robin pointer updates only on a grant; it resets to "last = B", so A wins the first conflict.
- Grant path:
  - ACK of the winner is combinational in the same cycle as its REQ.
  - RAM_EN=1; RAM_WE, RAM_ADDR, RAM_DI, RAM_DIP are muxed from the winner.
  - The loser's ACK=0; it keeps REQ high and its inputs stable.
- Read return: a read grant in cycle N drives the owner's RVALID=1 in cycle N+1. RDATA/RDATAP = RAM_DO/RAM_DOP pass-through.
- No grant: RAM_EN=0, RAM_WE=0.
- CLR has priority over REQs in the same IDLE cycle:
  - That cycle grants nothing; the sweep starts on the next cycle.
- CLEAR state:
  - Both ACKs = 0.
  - RAM_EN=RAM_WE=1, RAM_ADDR = 11-bit counter (0..2047, +1 per cycle).
  - RAM_DI/RAM_DIP = CLR_VAL[7:0]/CLR_VAL[8].
  - CLR_BUSY=1.
  - CLR is ignored while in CLEAR.
- After the write to 2047, the counter wraps to 0 and the FSM returns to IDLE. CLR_DONE=1 for exactly one cycle, the first IDLE cycle; grants may occur in that same cycle.
- A read granted in the last IDLE cycle before CLEAR still returns RVALID the next cycle.

## Timing
- Reset values:
  - State IDLE, clear counter 0, pointer "last = B".
  - A/B_RVALID=0, CLR_BUSY=0, CLR_DONE=0.
  - ACKs and RAM_EN/RAM_WE are forced 0 while RST_N=0.
- Read latency: 1 cycle from ACK to RVALID. Write completes at the ACK-cycle edge.
- Throughput: one transfer per cycle. Alternating grants under continuous contention.
- Clear: exactly 2048 cycles of CLR_BUSY. CLR_DONE comes on cycle 2049 after the CLR-sampled edge.
- Reset mid-clear: the sweep aborts immediately with no CLR_DONE. RAM contents are then partly cleared, which is acceptable.
- Reset also clears pending RVALID.

## Structure
- Shared package ramb_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR);
  - RAM_DEPTH=2048, RAM_AW=11, RAM_DW=8;
  - the requester-ID type (REQ_A, REQ_B).
- One sub-module, ramb_rr_arb2:
  - 2-way round-robin grant plus pointer register;
  - inputs: request vector and enable; outputs: one-hot grant.
- The top holds the FSM, clear counter, muxing and RVALID registers.

## Test plan
- A reads address 0x005 alone after reset:
  - A_ACK=1 the same cycle;
  - A_RVALID=1 the next cycle, with RDATA equal to the RAM contents at 0x005.
- A and B both hold REQ for 4 cycles:
  - grants go A,B,A,B;
  - B's write to 0x123 of 8'hA5/1 followed by A's read of 0x123 returns 8'hA5/1.
- CLR pulse with CLR_VAL=9'h1FF while B_REQ is high:
  - no ACK for 2049 cycles; CLR_BUSY high for 2048 cycles;
  - CLR_DONE pulses once; B is then granted;
  - reads of 0x000 and 0x7FF return 8'hFF/1.
- CLR pulse repeated during CLEAR: ignored, exactly one CLR_DONE.
- RST_N low at clear count 100:
  - all outputs return to reset values asynchronously, no CLR_DONE;
  - after release, A is granted first on contention.
- Read granted the cycle CLR is sampled at the next edge: RVALID still asserts, with correct data.
